branch_fwd_ctrl: RTL and testbench
==================================

BRANCH_FWD_CTRL -- requirements
Module: branch_fwd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 5: register address width.
- DEPTH, 3: in-flight producer stages tracked; index 0 = EX, 1 = MEM, 2 = WB.
- SEL_W, 2: forward-select width; 2^SEL_W >= DEPTH+1 required.
- ALU_LAT, 1: ALU result latency.
- LOAD_LAT, 2: load result latency.
- LAT_W, 2: latency counter width.
- BRANCH_ONLY, 1: 1 = hazard check on branches only; 0 = on all instructions.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset.
- id_valid, in, 1: ID holds a valid instruction.
- id_rs, in, AW: ID source register rs.
- id_rt, in, AW: ID source register rt.
- id_branch, in, 1: ID instruction is a branch.
- id_regwr, in, 1: ID instruction writes a register.
- id_wrreg, in, AW: ID destination register.
- id_memrd, in, 1: ID instruction is a load.
- flush, in, 1: kill the ID instruction.
- stall, out, 1: hold the PC and the ID register.
- fwd_rs_sel, out, SEL_W: rs operand source.
- fwd_rt_sel, out, SEL_W: rt operand source.

REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold a DEPTH-entry scoreboard; each entry is {valid, wrreg[AW], lat[LAT_W]}.
REQ-005 An entry SHALL be ready when valid=1 and lat=0.
REQ-006 Checking SHALL be active when id_valid=1, flush=0, and (id_branch=1 or BRANCH_ONLY=0).
REQ-007 For each operand (rs, rt) while checking is active, the search SHALL run from index 0 to DEPTH-1. The first valid entry with wrreg equal to the operand decides:
- entry ready: sel = index+1.
- entry not ready: operand hazard.
REQ-008 If no entry matches, if the operand is 0, or if checking is inactive, sel SHALL be 0 (register file).
REQ-009 stall SHALL equal (rs hazard OR rt hazard); the selects SHALL still be driven while stalling.
REQ-010 stall and both selects SHALL be combinational from the current scoreboard and ID inputs, with zero-cycle latency.
REQ-011 On each clk rising edge:
- entry k SHALL move to k+1, with lat decremented and saturating at 0.
- entry DEPTH-1 SHALL retire; the register file then holds the value (write-before-read).
REQ-012 Entry 0 SHALL load {1, id_wrreg, id_memrd ? LOAD_LAT : ALU_LAT} only when id_valid=1, id_regwr=1, id_wrreg!=0, stall=0 and flush=0. Otherwise it SHALL load a bubble (valid=0).
REQ-013 flush=1 SHALL force stall=0 and both selects to 0, and insert a bubble; flush overrides a pending stall.
REQ-014 A younger not-ready match SHALL stall even when an older ready match to the same register exists; stale data is never forwarded.
REQ-015 ALU_LAT and LOAD_LAT SHALL each be in 1..DEPTH and fit in LAT_W bits.

Reset
REQ-016 rst_n=0 SHALL immediately clear every entry (valid=0, wrreg=0, lat=0), including mid-stall, giving stall=0 and both selects=0.
REQ-017 The first rising edge after rst_n deasserts SHALL perform normal insertion.

Configuration
REQ-018 With macro BRANCH_FWD_PERF_EN defined, the block SHALL add:
- input perf_clr (1 bit).
- output stall_cnt (32 bits), reset to 0, incremented on each edge where stall=1 and saturating at 0xFFFFFFFF.
- perf_clr=1 SHALL zero stall_cnt, taking priority over increment.
REQ-019 Without BRANCH_FWD_PERF_EN, perf_clr, stall_cnt and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults)
REQ-020 ALU writes r5 at cycle n; branch with rs=5 at n+1 -> stall=1 for 1 cycle; at n+2 stall=0 and fwd_rs_sel=2.
REQ-021 Load writes r7; next cycle, branch with rt=7 -> stall=1 for 2 cycles, then fwd_rt_sel=3; an unrelated rs gives fwd_rs_sel=0.
REQ-022 ALU writes r3, then a second ALU writes r3, then branch with rs=3 -> stall=1 (younger entry not ready), then fwd_rs_sel=2 from the younger entry.
REQ-023 Producer with id_wrreg=0, then branch with rs=0 -> stall=0, fwd_rs_sel=0; the scoreboard holds no valid entry.
REQ-024 Mid-stall cases:
- flush=1 during a stall -> stall=0 in the same cycle, and entry 0 is a bubble next cycle.
- rst_n pulsed low during a stall -> stall=0 immediately.
REQ-025 With BRANCH_FWD_PERF_EN defined: 3 stall cycles -> stall_cnt=3; perf_clr=1 for 1 cycle -> 0. Without the macro: ports absent and outputs unchanged from REQ-020 to REQ-024.

Source files
------------

// File: rtl/branch_fwd_ctrl.sv
// rtl/branch_fwd_ctrl.sv - branch operand forwarding/stall control over a shifting producer scoreboard
// Optional stall counter is enabled with macro BRANCH_FWD_PERF_EN.
module branch_fwd_ctrl #(
  parameter int AW          = 5,
  parameter int DEPTH       = 3,
  parameter int SEL_W       = 2,
  parameter int ALU_LAT     = 1,
  parameter int LOAD_LAT    = 2,
  parameter int LAT_W       = 2,
  parameter int BRANCH_ONLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_branch,
  input  logic             id_regwr,
  input  logic [AW-1:0]    id_wrreg,
  input  logic             id_memrd,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel
`ifdef BRANCH_FWD_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      stall_cnt
`endif
);

  if ((1 << SEL_W) < (DEPTH + 1)) begin : g_bad_sel_w
    $error("branch_fwd_ctrl: SEL_W too narrow for DEPTH");
  end
  if ((ALU_LAT < 1) || (ALU_LAT > DEPTH) || (ALU_LAT >= (1 << LAT_W))) begin : g_bad_alu_lat
    $error("branch_fwd_ctrl: ALU_LAT out of range");
  end
  if ((LOAD_LAT < 1) || (LOAD_LAT > DEPTH) || (LOAD_LAT >= (1 << LAT_W))) begin : g_bad_load_lat
    $error("branch_fwd_ctrl: LOAD_LAT out of range");
  end

  logic             r_valid [DEPTH];
  logic [AW-1:0]    r_wrreg [DEPTH];
  logic [LAT_W-1:0] r_lat   [DEPTH];

  logic             w_check;
  logic             w_ins;
  logic             w_rs_haz;
  logic             w_rt_haz;
  logic [SEL_W:0]   w_rs_res;
  logic [SEL_W:0]   w_rt_res;

  // Youngest matching producer wins: {hazard, select}. A not-ready younger
  // match must hide any older ready copy of the same register.
  function automatic logic [SEL_W:0] f_lookup(input logic [AW-1:0] operand);
    logic           found;
    logic [SEL_W:0] res;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && r_valid[k] && (r_wrreg[k] == operand)) begin
        found = 1'b1;
        if (r_lat[k] == '0) begin
          res = {1'b0, SEL_W'(k + 1)};
        end else begin
          res = {1'b1, {SEL_W{1'b0}}};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_check  = id_valid && !flush && (id_branch || (BRANCH_ONLY == 0));
    w_rs_res = f_lookup(id_rs);
    w_rt_res = f_lookup(id_rt);
    w_rs_haz = w_check && (id_rs != '0) && w_rs_res[SEL_W];
    w_rt_haz = w_check && (id_rt != '0) && w_rt_res[SEL_W];
  end

  assign stall      = w_rs_haz | w_rt_haz;
  assign fwd_rs_sel = (w_check && (id_rs != '0)) ? w_rs_res[SEL_W-1:0] : '0;
  assign fwd_rt_sel = (w_check && (id_rt != '0)) ? w_rt_res[SEL_W-1:0] : '0;

  assign w_ins = id_valid && id_regwr && (id_wrreg != '0) && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_wrreg[k] <= '0;
        r_lat[k]   <= '0;
      end
    end else begin
      r_valid[0] <= w_ins;
      r_wrreg[0] <= w_ins ? id_wrreg : '0;
      r_lat[0]   <= w_ins ? (id_memrd ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT)) : '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wrreg[k] <= r_wrreg[k-1];
        r_lat[k]   <= (r_lat[k-1] == '0) ? '0 : (r_lat[k-1] - LAT_W'(1));
      end
    end
  end

`ifdef BRANCH_FWD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// tb/tb_branch_fwd_ctrl.sv - directed checks for branch_fwd_ctrl (BRANCH_FWD_PERF_EN adds counter checks)
module tb_branch_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_branch;
  logic       id_regwr;
  logic [4:0] id_wrreg;
  logic       id_memrd;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
`ifdef BRANCH_FWD_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  branch_fwd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_branch  (id_branch),
    .id_regwr   (id_regwr),
    .id_wrreg   (id_wrreg),
    .id_memrd   (id_memrd),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
`ifdef BRANCH_FWD_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic wr, input logic [4:0] wreg, input logic mrd);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_branch = br;
    id_regwr  = wr;
    id_wrreg  = wreg;
    id_memrd  = mrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    flush = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      n_errors++; $display("FAIL reset_sel: got rs=%0d rt=%0d want 0 0", fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_alu_fwd();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL alu_stall: got %0b want 1", stall); end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL alu_release: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs_sel !== 2'd2) begin n_errors++; $display("FAIL alu_rs_sel: got %0d want 2", fwd_rs_sel); end
    tick();
    drain();
  endtask

  task automatic test_load_fwd();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL load_stall1: got %0b want 1", stall); end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL load_stall2: got %0b want 1", stall); end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL load_release: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rt_sel !== 2'd3) begin n_errors++; $display("FAIL load_rt_sel: got %0d want 3", fwd_rt_sel); end
    n_checks++;
    if (fwd_rs_sel !== 2'd0) begin n_errors++; $display("FAIL load_rs_sel: got %0d want 0", fwd_rs_sel); end
    tick();
    drain();
  endtask

  task automatic test_younger_match();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
      n_errors++; $display("FAIL nonbranch_nocheck: got stall=%0b rs=%0d want 0 0", stall, fwd_rs_sel);
    end
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL younger_stall: got %0b want 1", stall); end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd2) begin
      n_errors++; $display("FAIL younger_sel: got stall=%0b rs=%0d want 0 2", stall, fwd_rs_sel);
    end
    tick();
    drain();
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      n_errors++; $display("FAIL zero_reg: got stall=%0b rs=%0d rt=%0d want 0 0 0", stall, fwd_rs_sel, fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd3 || fwd_rt_sel !== 2'd2) begin
      n_errors++; $display("FAIL b2b_sel: got stall=%0b rs=%0d rt=%0d want 0 3 2", stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    set_id(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd2) begin
      n_errors++; $display("FAIL b2b_retire: got stall=%0b rs=%0d rt=%0d want 0 0 2", stall, fwd_rs_sel, fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_flush_mid_stall();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_pre_stall: got %0b want 1", stall); end
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
      n_errors++; $display("FAIL flush_kill: got stall=%0b rs=%0d want 0 0", stall, fwd_rs_sel);
    end
    tick();
    flush = 1'b0;
    set_id(1'b1, 5'd8, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd2) begin
      n_errors++; $display("FAIL flush_bubble: got stall=%0b rs=%0d rt=%0d want 0 0 2", stall, fwd_rs_sel, fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_pre_stall: got %0b want 1", stall); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
      n_errors++; $display("FAIL rst_async_clear: got stall=%0b rs=%0d want 0 0", stall, fwd_rs_sel);
    end
    tick();
    rst_n = 1'b1;
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
      n_errors++; $display("FAIL rst_after: got stall=%0b rs=%0d want 0 0", stall, fwd_rs_sel);
    end
    tick();
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_first_insert: got %0b want 1", stall); end
    drain();
  endtask

`ifdef BRANCH_FWD_PERF_EN
  task automatic test_perf();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (2) tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'd3) begin n_errors++; $display("FAIL perf_count: got %0d want 3", stall_cnt); end
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL perf_clear: got %0d want 0", stall_cnt); end
    drain();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
`ifdef BRANCH_FWD_PERF_EN
    perf_clr = 1'b0;
`endif
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_alu_fwd();
    test_load_fwd();
    test_younger_match();
    test_zero_reg();
    test_back_to_back();
    test_flush_mid_stall();
    test_reset_mid_stall();
`ifdef BRANCH_FWD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
